// File: rtl/tt_serial_tx.sv
// Serial transmitter: 4-deep x 5-bit FIFO feeding a start/5-data/stop frame on io_o[0].
// Define TT_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module tt_serial_tx #(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic [7:0] io_i,
    output logic [7:0] io_o
);
    localparam logic [7:0] RELOAD = 8'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TT_SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [4:0] din;

    assign clk   = io_i[0];
    assign rst_n = io_i[1];
    assign wr    = io_i[2];
    assign din   = io_i[7:3];

    logic       wr_q;
    logic       armed;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       ovf;
    logic [4:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    state_t     state;
    state_t     state_d;
    logic [7:0] cnt;
    logic [7:0] cnt_d;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_d;
    logic [4:0] shift;
    logic [4:0] shift_d;
    logic       txd;
    logic       busy;
`ifdef TT_SERIAL_TX_PARITY_EN
    logic       parity_q;
    logic       parity_d;
`endif

    // armed stays low after reset until wr is seen low, so a strobe held
    // through reset release is not mistaken for a fresh rising edge.
    assign push_req = wr & ~wr_q & armed;
    assign pop      = (state == IDLE) && (count != 3'd0);
    assign push_ok  = push_req && ((count != 3'd4) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            armed  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_q <= wr;
            if (!wr) begin
                armed <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef TT_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
`ifdef TT_SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
`ifdef TT_SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        txd       = 1'b1;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pop) begin
                    shift_d = mem[rd_ptr];
`ifdef TT_SERIAL_TX_PARITY_EN
                    parity_d = ^mem[rd_ptr];
`endif
                    cnt_d   = RELOAD;
                    state_d = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (cnt == 8'd0) begin
                    cnt_d     = RELOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            DATA: begin
                txd = shift[0];
                if (cnt == 8'd0) begin
                    cnt_d = RELOAD;
                    if (bit_idx == 3'd4) begin
`ifdef TT_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        shift_d   = {1'b0, shift[4:1]};
                    end
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
`ifdef TT_SERIAL_TX_PARITY_EN
            PARITY: begin
                txd = parity_q;
                if (cnt == 8'd0) begin
                    cnt_d   = RELOAD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io_o = {count, ovf, (count == 3'd0), (count == 3'd4), busy, txd};

endmodule

// File: tb/tb_tt_serial_tx.sv
// Directed bench for tt_serial_tx: reset/idle, frame timing, wr level handling,
// FIFO fill/overflow with back-to-back frames, and reset abort mid-frame.
module tb_tt_serial_tx;
    localparam int BD = 4;
`ifdef TT_SERIAL_TX_PARITY_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr    = 1'b0;
    logic [4:0] data  = 5'd0;
    logic [7:0] io_i;
    logic [7:0] io_o;

    assign io_i = {data, wr, rst_n, clk};

    tt_serial_tx #(.BAUD_DIV(BD)) dut (
        .io_i(io_i),
        .io_o(io_o)
    );

    always #5 clk = ~clk;

    logic txd, busy;
    assign txd  = io_o[0];
    assign busy = io_o[1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_hold  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_hold > 0) begin
            wr_hold--;
            if (wr_hold == 0) wr = 1'b0;
        end
    endtask

    // Returns one cycle after the push edge (the edge that pops into an idle transmitter).
    task automatic push(input logic [4:0] w);
        data = w;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
        tick();
    endtask

    function automatic logic bit_exp(input logic [4:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 5) return w[k-1];
        if (NB == 8 && k == 6) return ^w;
        return 1'b1;
    endfunction

    // Called one cycle into START; returns on the first IDLE cycle after STOP.
    task automatic expect_frame(input logic [4:0] w, input string tag);
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < BD; j++) begin
                check(tag, {30'd0, busy, txd}, {30'd0, 1'b1, bit_exp(w, k)});
                tick();
            end
        end
        check({tag, "_idle"}, {30'd0, busy, txd}, 32'd1);
    endtask

    task automatic quiet_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int s;
        int bad;

        // Reset and idle
        tick();
        check("reset_io", io_o, 8'h09);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_io", io_o, 8'h09);
        end

        // Single frame, first check is the 1-cycle push-to-start latency
        push(5'b10110);
        check("latency_txd", txd, 1'b0);
        expect_frame(5'b10110, "frame_10110");
        check("after_frame_empty", io_o[7:2], {3'd0, 1'b0, 1'b1, 1'b0});

        // wr held high for 10 edges: exactly one push
        data    = 5'b00001;
        wr      = 1'b1;
        wr_hold = 10;
        tick();
        tick();
        expect_frame(5'b00001, "frame_hold");
        check("hold_empty", io_o[7:2], {3'd0, 1'b0, 1'b1, 1'b0});
        quiet_check("hold_no_second", 20);

        // Fill while in flight, overflow, push coincident with pop at full
        push(5'b00011);
        s = cyc;
        check("fill_first_start", txd, 1'b0);
        push(5'b00100);
        push(5'b01101);
        push(5'b11110);
        push(5'b10001);
        check("fill_full", io_o[7:2], {3'd4, 1'b0, 1'b0, 1'b1});
        push(5'b11111);
        check("ovf_drop", io_o[7:2], {3'd4, 1'b1, 1'b0, 1'b1});
        while (cyc < s + 28) tick();
        check("full_gap_idle", {30'd0, busy, txd}, 32'd1);
        data = 5'b01011;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
        check("push_pop_full", io_o[7:2], {3'd4, 1'b1, 1'b0, 1'b1});
        expect_frame(5'b00100, "q_b");
        tick();
        expect_frame(5'b01101, "q_c");
        tick();
        expect_frame(5'b11110, "q_d");
        tick();
        expect_frame(5'b10001, "q_e");
        tick();
        expect_frame(5'b01011, "q_g");
        check("drain_empty", io_o[7:2], {3'd0, 1'b1, 1'b1, 1'b0});
        quiet_check("drain_quiet", 20);

        // Reset mid-frame with two words queued, wr held high across release
        rst_n = 1'b0;
        tick();
        check("reset2_io", io_o, 8'h09);
        rst_n = 1'b1;
        tick();
        push(5'b01010);
        s = cyc;
        push(5'b00111);
        push(5'b11000);
        check("abort_occ", io_o[7:5], 3'd2);
        while (cyc < s + 13) tick();
        check("abort_bit2", txd, 1'b0);
        #2;
        rst_n = 1'b0;
        wr    = 1'b1;
        data  = 5'b11111;
        #1;
        check("abort_async_io", io_o, 8'h09);
        tick();
        tick();
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (io_o !== 8'h09) bad++;
        end
        check("abort_no_frame", bad, 0);
        wr = 1'b0;
        tick();
        tick();
        push(5'b00110);
        expect_frame(5'b00110, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
